lsu_mem: RTL and testbench

LSU_MEM -- requirements
Module: lsu_mem

---
 rtl/lsu_mem_if.sv | 28 ++
 rtl/lsu_mem.sv | 195 +++++++++++++++++++
 tb/tb_lsu_mem.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_if
// Purpose  : Request/response bundle between a load/store unit and lsu_mem.
// Revision : 1.0  initial release
// ============================================================================
interface lsu_mem_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface
`default_nettype wire

// File: rtl/lsu_mem.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem
// Purpose  : RV32I-style byte-addressable data memory with fixed wait states.
//            Define LSU_MEM_ERR_EN to flag misaligned/out-of-range accesses.
// Revision : 1.0  initial release
// ============================================================================
module lsu_mem #(
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 0
) (
   input  logic      clk,
   input  logic      rst,
   lsu_mem_if.slave  bus
);

   localparam int         c_aw        = $clog2(DEPTH);
   localparam logic [3:0] c_wait_init = 4'(WAIT_CYCLES);
   localparam logic [2:0] c_f3_b      = 3'b000;
   localparam logic [2:0] c_f3_h      = 3'b001;
   localparam logic [2:0] c_f3_w      = 3'b010;
   localparam logic [2:0] c_f3_bu     = 3'b100;
   localparam logic [2:0] c_f3_hu     = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_nxt;
   logic        w_ready;
   logic        w_accept;
   logic        w_access;

   logic        r_we;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;

   logic        r_rsp_valid;
   logic [31:0] r_rsp_rdata;
   logic        r_rsp_err;

   logic        w_is_byte;
   logic        w_is_half;
   logic        w_illegal;
   logic        w_fault;
   logic [1:0]  w_lane;
   logic [c_aw-1:0] w_idx;
   wire  [31:0] w_word;
   logic [15:0] w_lane_data;
   logic [31:0] w_load;
   logic [3:0]  w_be;
   logic [31:0] w_wdata_rep;

   assign w_ready  = (r_state == ST_IDLE) && !rst;
   assign w_accept = bus.req_valid && w_ready;

   assign bus.req_ready = w_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.rsp_err   = r_rsp_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_access    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_WAIT;
               w_cnt_nxt   = c_wait_init;
            end
         end
         ST_WAIT: begin
            if (r_cnt == 4'd0) begin
               w_state_nxt = ST_RESP;
               w_access    = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         ST_RESP: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Everything downstream works from the latched request, never the live bus.
   assign w_is_byte = (r_funct3[1:0] == 2'b00);
   assign w_is_half = (r_funct3[1:0] == 2'b01);
   assign w_illegal = r_we ? (r_funct3 > 3'b010)
                           : ((r_funct3 == 3'b011) || (r_funct3[2:1] == 2'b11));
   assign w_lane    = w_is_byte ? r_addr[1:0] :
                      w_is_half ? {r_addr[1], 1'b0} : 2'b00;
   assign w_idx     = r_addr[c_aw+1:2];

`ifdef LSU_MEM_ERR_EN
   localparam logic [32:0] c_byte_limit = 33'(DEPTH) << 2;
   logic w_misalign;
   logic w_oob;
   assign w_misalign = (w_is_half && r_addr[0]) ||
                       ((r_funct3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
   assign w_oob      = ({1'b0, r_addr} >= c_byte_limit);
   assign w_fault    = w_illegal || w_misalign || w_oob;
`else
   logic w_unused_addr_hi;
   assign w_unused_addr_hi = ^r_addr[31:c_aw+2];
   assign w_fault          = w_illegal;
`endif

   always_comb begin
      w_be        = 4'b0000;
      w_wdata_rep = r_wdata;
      if (r_we && !w_fault) begin
         case (r_funct3)
            c_f3_b: begin
               w_be        = 4'b0001 << w_lane;
               w_wdata_rep = {4{r_wdata[7:0]}};
            end
            c_f3_h: begin
               w_be        = 4'b0011 << w_lane;
               w_wdata_rep = {2{r_wdata[15:0]}};
            end
            c_f3_w:  w_be = 4'b1111;
            default: w_be = 4'b0000;
         endcase
      end
   end

   // One byte-wide bank per lane keeps byte-enable writes RAM friendly.
   for (genvar g = 0; g < 4; g++) begin : g_lane
      logic [7:0] r_bank [DEPTH];

      always_ff @(posedge clk) begin
         if (w_access && !rst && w_be[g]) begin
            r_bank[w_idx] <= w_wdata_rep[g*8 +: 8];
         end
      end

      assign w_word[g*8 +: 8] = r_bank[w_idx];
   end

   assign w_lane_data = 16'(w_word >> {w_lane, 3'b000});

   always_comb begin
      w_load = w_word;
      case (r_funct3)
         c_f3_b:  w_load = {{24{w_lane_data[7]}},  w_lane_data[7:0]};
         c_f3_h:  w_load = {{16{w_lane_data[15]}}, w_lane_data};
         c_f3_bu: w_load = {24'd0, w_lane_data[7:0]};
         c_f3_hu: w_load = {16'd0, w_lane_data};
         default: w_load = w_word;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we        <= 1'b0;
         r_funct3    <= 3'd0;
         r_addr      <= 32'd0;
         r_wdata     <= 32'd0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 32'd0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_rsp_valid <= w_access;
         if (w_accept) begin
            r_we     <= bus.req_we;
            r_funct3 <= bus.req_funct3;
            r_addr   <= bus.req_addr;
            r_wdata  <= bus.req_wdata;
         end
         if (w_access) begin
            r_rsp_err   <= w_fault;
            r_rsp_rdata <= (r_we || w_fault) ? 32'd0 : w_load;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem
// Purpose  : Directed self-checking bench for lsu_mem (WAIT_CYCLES 2 and 0).
// Revision : 1.0  initial release
// ============================================================================
module tb_lsu_mem;

   localparam logic [2:0] c_b  = 3'b000;
   localparam logic [2:0] c_h  = 3'b001;
   localparam logic [2:0] c_w  = 3'b010;
   localparam logic [2:0] c_bu = 3'b100;
   localparam logic [2:0] c_hu = 3'b101;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   lsu_mem_if bus ();
   lsu_mem_if bus0 ();

   lsu_mem #(.DEPTH(1024), .WAIT_CYCLES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   lsu_mem #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic v, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
      if (sel) begin
         bus0.req_valid = v; bus0.req_we = we; bus0.req_funct3 = f3;
         bus0.req_addr  = a; bus0.req_wdata = d;
      end else begin
         bus.req_valid = v; bus.req_we = we; bus.req_funct3 = f3;
         bus.req_addr  = a; bus.req_wdata = d;
      end
   endtask

   function automatic logic rd_ready(input bit sel);
      return sel ? bus0.req_ready : bus.req_ready;
   endfunction
   function automatic logic rd_rv(input bit sel);
      return sel ? bus0.rsp_valid : bus.rsp_valid;
   endfunction
   function automatic logic [31:0] rd_rdata(input bit sel);
      return sel ? bus0.rsp_rdata : bus.rsp_rdata;
   endfunction
   function automatic logic rd_err(input bit sel);
      return sel ? bus0.rsp_err : bus.rsp_err;
   endfunction

   // One request; inputs are scrambled right after accept to prove they are latched.
   task automatic xact(input bit sel, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rdata, output logic err,
                       output int lat, output logic held);
      int n;
      @(negedge clk);
      drive(sel, 1'b1, we, f3, a, d);
      n = 0;
      while (!rd_ready(sel) && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      drive(sel, 1'b0, ~we, 3'b111, ~a, ~d);
      lat = -1;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk);
         #1;
         if (rd_rv(sel)) begin
            lat = c;
            break;
         end
      end
      rdata = rd_rdata(sel);
      err   = rd_err(sel);
      @(posedge clk);
      #1;
      held = !rd_rv(sel) && (rd_rdata(sel) === rdata) && (rd_err(sel) === err);
   endtask

   task automatic op(input string tag, input bit sel, input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
      logic [31:0] rdata;
      logic        err;
      int          lat;
      logic        held;
      xact(sel, we, f3, a, d, rdata, err, lat, held);
      check_val({tag, "_rdata"}, rdata, exp_rd);
      check_val({tag, "_err"}, 32'(err), 32'(exp_err));
      check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check_val({tag, "_pulse_hold"}, 32'(held), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, first_rv, acc2, busy_lo;
      logic [31:0] rd2;
      logic rv_seen;

      drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_val("rst_ready", 32'(bus.req_ready), 32'd0);
      check_val("rst_rv",    32'(bus.rsp_valid), 32'd0);
      check_val("rst_rdata", bus.rsp_rdata,      32'd0);
      check_val("rst_err",   32'(bus.rsp_err),   32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_val("idle_ready", 32'(bus.req_ready), 32'd1);

      op("sw10",   1'b0, 1'b1, c_w,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 3);
      op("lw10",   1'b0, 1'b0, c_w,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3);
      op("sb13",   1'b0, 1'b1, c_b,  32'h13, 32'h000000A5, 32'h0,        1'b0, 3);
      op("lb13",   1'b0, 1'b0, c_b,  32'h13, 32'h0,        32'hFFFFFFA5, 1'b0, 3);
      op("lbu13",  1'b0, 1'b0, c_bu, 32'h13, 32'h0,        32'h000000A5, 1'b0, 3);
      op("lw10b",  1'b0, 1'b0, c_w,  32'h10, 32'h0,        32'hA5ADBEEF, 1'b0, 3);
      op("sh12",   1'b0, 1'b1, c_h,  32'h12, 32'h00001234, 32'h0,        1'b0, 3);
      op("lw10c",  1'b0, 1'b0, c_w,  32'h10, 32'h0,        32'h1234BEEF, 1'b0, 3);
      op("lh10",   1'b0, 1'b0, c_h,  32'h10, 32'h0,        32'hFFFFBEEF, 1'b0, 3);
      op("lhu10",  1'b0, 1'b0, c_hu, 32'h10, 32'h0,        32'h0000BEEF, 1'b0, 3);
`ifdef LSU_MEM_ERR_EN
      op("lw11",   1'b0, 1'b0, c_w,  32'h11, 32'h0,        32'h0,        1'b1, 3);
      op("lh13",   1'b0, 1'b0, c_h,  32'h13, 32'h0,        32'h0,        1'b1, 3);
`else
      op("lw11",   1'b0, 1'b0, c_w,  32'h11, 32'h0,        32'h1234BEEF, 1'b0, 3);
      op("lh13",   1'b0, 1'b0, c_h,  32'h13, 32'h0,        32'h00001234, 1'b0, 3);
`endif
      op("ld_f3_011", 1'b0, 1'b0, 3'b011, 32'h10, 32'h0,   32'h0,        1'b1, 3);
      op("ld_f3_110", 1'b0, 1'b0, 3'b110, 32'h10, 32'h0,   32'h0,        1'b1, 3);
      op("st_f3_011", 1'b0, 1'b1, 3'b011, 32'h10, 32'hFFFFFFFF, 32'h0,   1'b1, 3);
      op("lw10d",  1'b0, 1'b0, c_w,  32'h10, 32'h0,        32'h1234BEEF, 1'b0, 3);

      op("sw0",    1'b0, 1'b1, c_w,  32'h0,    32'h0BADF00D, 32'h0,      1'b0, 3);
`ifdef LSU_MEM_ERR_EN
      op("sw1000", 1'b0, 1'b1, c_w,  32'h1000, 32'hCAFEF00D, 32'h0,      1'b1, 3);
      op("lw0",    1'b0, 1'b0, c_w,  32'h0,    32'h0,        32'h0BADF00D, 1'b0, 3);
`else
      op("sw1000", 1'b0, 1'b1, c_w,  32'h1000, 32'hCAFEF00D, 32'h0,      1'b0, 3);
      op("lw0",    1'b0, 1'b0, c_w,  32'h0,    32'h0,        32'hCAFEF00D, 1'b0, 3);
`endif

      // req_valid held across two requests: LW 0x10 then LH 0x10.
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, c_w, 32'h10, 32'h0);
      acc = 0; first_rv = -1; acc2 = -1; busy_lo = 0; rd2 = 32'h0;
      for (int k = 0; k < 14; k++) begin
         if (k > 0) @(negedge clk);
         if (bus.rsp_valid) begin
            if (first_rv < 0) first_rv = k;
            else              rd2 = bus.rsp_rdata;
         end
         if (bus.req_valid && bus.req_ready) begin
            acc++;
            if (acc == 2) acc2 = k;
         end else if (acc == 1 && !bus.req_ready) begin
            busy_lo++;
         end
         @(posedge clk);
         #1;
         if (acc == 1)      drive(1'b0, 1'b1, 1'b0, c_h, 32'h10, 32'h0);
         else if (acc == 2) drive(1'b0, 1'b0, 1'b0, c_w, 32'h0, 32'h0);
      end
      check_val("b2b_accepts",  32'(acc),      32'd2);
      check_val("b2b_first_rv", 32'(first_rv), 32'd4);
      check_val("b2b_acc2",     32'(acc2),     32'd5);
      check_val("b2b_busy_lo",  32'(busy_lo),  32'd4);
      check_val("b2b_rd2",      rd2,           32'hFFFFBEEF);

      op("z_sw40", 1'b1, 1'b1, c_w,  32'h40, 32'h13579BDF, 32'h0,        1'b0, 1);
      op("z_lw40", 1'b1, 1'b0, c_w,  32'h40, 32'h0,        32'h13579BDF, 1'b0, 1);
      op("z_lbu41",1'b1, 1'b0, c_bu, 32'h41, 32'h0,        32'h0000009B, 1'b0, 1);

      // Reset mid-WAIT aborts a store; outputs clear without waiting for clk.
      op("sw20",   1'b0, 1'b1, c_w,  32'h20, 32'h11111111, 32'h0,        1'b0, 3);
      op("lw10e",  1'b0, 1'b0, c_w,  32'h10, 32'h0,        32'h1234BEEF, 1'b0, 3);
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, c_w, 32'h20, 32'h22222222);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 1'b0, c_w, 32'h0, 32'h0);
      check_val("abort_busy_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_val("abort_ready", 32'(bus.req_ready), 32'd0);
      check_val("abort_rv",    32'(bus.rsp_valid), 32'd0);
      check_val("abort_rdata", bus.rsp_rdata,      32'd0);
      check_val("abort_err",   32'(bus.rsp_err),   32'd0);
      rv_seen = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         rv_seen = rv_seen | bus.rsp_valid;
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
         rv_seen = rv_seen | bus.rsp_valid;
      end
      check_val("abort_no_rsp", 32'(rv_seen), 32'd0);
      op("lw20",   1'b0, 1'b0, c_w,  32'h20, 32'h0,        32'h11111111, 1'b0, 3);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
